// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core.
//   - ROB geometry and datapath widths
//   - rob_entry_t: one reorder-buffer entry {busy, done, dest, value}
//   - opcode and reservation-station index constants used by the issue logic
//   - rob_next_ptr: pointer increment with natural wrap (ROB_DEPTH is a power of 2)
package tomasulo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int TAG_W     = 3;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    STORE = 3'd1,
    ADD   = 3'd2,
    SUB   = 3'd3,
    MUL   = 3'd4,
    DIV   = 3'd5
  } opcode_e;

  localparam int RS_W = 4;
  localparam logic [RS_W-1:0] RS_LS_FIRST  = 4'd0;
  localparam logic [RS_W-1:0] RS_LS_LAST   = 4'd5;
  localparam logic [RS_W-1:0] RS_ADD_FIRST = 4'd6;
  localparam logic [RS_W-1:0] RS_ADD_LAST  = 4'd8;
  localparam logic [RS_W-1:0] RS_MUL_FIRST = 4'd9;
  localparam logic [RS_W-1:0] RS_MUL_LAST  = 4'd10;
  localparam logic [RS_W-1:0] RS_NONE      = 4'd11;

  function automatic logic [TAG_W-1:0] rob_next_ptr(input logic [TAG_W-1:0] ptr);
    return ptr + TAG_W'(1);
  endfunction

endpackage

// File: rtl/rob_entry.sv
// One reorder-buffer entry: storage plus its alloc / CDB capture / retire update.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset (clears everything)
//   flush         drop the entry (busy/done cleared, dest/value kept)
//   alloc_en      claim this entry for a newly issued instruction
//   alloc_dest    destination register of that instruction
//   cdb_en        CDB broadcast addressed to this entry
//   cdb_data      broadcast result
//   clear         entry is retiring this cycle
//   busy, done, dest, value   registered entry state
module rob_entry
  import tomasulo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_en,
  input  logic [REG_W-1:0]  alloc_dest,
  input  logic              cdb_en,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] value
);

  rob_entry_t ent_q;

  // The controller never allocates a busy entry and only retires a done one,
  // so clear/CDB/alloc cannot meaningfully collide on one entry; the busy &&
  // !done guard makes a CDB hit on a free or finished entry a no-op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else if (flush) begin
      ent_q.busy <= 1'b0;
      ent_q.done <= 1'b0;
    end else begin
      if (clear) begin
        ent_q.busy <= 1'b0;
        ent_q.done <= 1'b0;
      end
      if (cdb_en && ent_q.busy && !ent_q.done) begin
        ent_q.done  <= 1'b1;
        ent_q.value <= cdb_data;
      end
      if (alloc_en) begin
        ent_q.busy <= 1'b1;
        ent_q.done <= 1'b0;
        ent_q.dest <= alloc_dest;
      end
    end
  end

  assign busy  = ent_q.busy;
  assign done  = ent_q.done;
  assign dest  = ent_q.dest;
  assign value = ent_q.value;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: allocates a tag per issued instruction, captures
// CDB results, and retires entries in program order to the register file.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   alloc_valid/alloc_dest              issue request and its destination
//   alloc_ready/alloc_tag               entry available, tag granted (tail)
//   cdb_valid/cdb_tag/cdb_data          result broadcast
//   commit_valid/commit_ready           retirement handshake for the head entry
//   commit_tag/commit_dest/commit_data  head entry being retired
//   flush                               discard all speculative entries
//   busy, count, full, empty            occupancy status
module rob_ctrl
  import tomasulo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_valid,
  input  logic [REG_W-1:0]     alloc_dest,
  output logic                 alloc_ready,
  output logic [TAG_W-1:0]     alloc_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [DATA_W-1:0]    cdb_data,
  output logic                 commit_valid,
  input  logic                 commit_ready,
  output logic [TAG_W-1:0]     commit_tag,
  output logic [REG_W-1:0]     commit_dest,
  output logic [DATA_W-1:0]    commit_data,
  input  logic                 flush,
  output logic [ROB_DEPTH-1:0] busy,
  output logic [TAG_W:0]       count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(ROB_DEPTH);

  logic [TAG_W-1:0]  head_q, tail_q;
  logic [TAG_W:0]    count_q;
  logic              alloc_fire, commit_fire;
  logic [ROB_DEPTH-1:0] busy_v, done_v;
  logic [REG_W-1:0]  dest_v  [ROB_DEPTH];
  logic [DATA_W-1:0] value_v [ROB_DEPTH];

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // full is based on the pre-commit count, so a full ROB refuses an alloc
  // even in the cycle its head retires.
  assign alloc_fire  = alloc_valid && !full;
  // Driven purely from registered entry state: a CDB write to the head shows
  // up here one cycle later, never in the same cycle.
  assign commit_valid = busy_v[head_q] && done_v[head_q];
  assign commit_fire  = commit_valid && commit_ready;

  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_ent
    rob_entry u_ent (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .alloc_en   (alloc_fire && (tail_q == TAG_W'(i))),
      .alloc_dest (alloc_dest),
      .cdb_en     (cdb_valid && (cdb_tag == TAG_W'(i))),
      .cdb_data   (cdb_data),
      .clear      (commit_fire && (head_q == TAG_W'(i))),
      .busy       (busy_v[i]),
      .done       (done_v[i]),
      .dest       (dest_v[i]),
      .value      (value_v[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc_fire)  tail_q <= rob_next_ptr(tail_q);
      if (commit_fire) head_q <= rob_next_ptr(head_q);
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;
  assign commit_tag  = head_q;
  assign commit_dest = dest_v[head_q];
  assign commit_data = value_v[head_q];
  assign busy        = busy_v;
  assign count       = count_q;

endmodule
